// File: rtl/fft_sched.sv
// Address sequencer for an in-place radix-2 DIT FFT driving one butterfly unit.
// Walks stages and butterflies, then replays the read addresses LAT cycles later as write-back.
module fft_sched #(
    parameter  int LOG2_PTS = 3,
    parameter  int LAT      = 1,
    localparam int SW       = (LOG2_PTS > 2) ? $clog2(LOG2_PTS) : 1,
    localparam int KW       = LOG2_PTS - 1
) (
    input  logic                clk_i,
    input  logic                reset,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [SW-1:0]       stage_o,
    output logic                rd_en_o,
    output logic [LOG2_PTS-1:0] rd_addr_a_o,
    output logic [LOG2_PTS-1:0] rd_addr_b_o,
    output logic [KW-1:0]       tw_idx_o,
    output logic                wr_en_o,
    output logic [LOG2_PTS-1:0] wr_addr_a_o,
    output logic [LOG2_PTS-1:0] wr_addr_b_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [SW-1:0] S_LAST   = SW'(LOG2_PTS - 1);
    localparam logic [KW-1:0] K_LAST   = '1;
    localparam logic [2:0]    CNT_LAST = 3'(LAT - 1);

    state_t            state_q, state_d;
    logic [SW-1:0]     s_q, s_d;
    logic [KW-1:0]     k_q, k_d;
    logic [2:0]        cnt_q, cnt_d;

    logic [LOG2_PTS-1:0] kExt, hVal, pos, grp, addrA, twFull;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    // The drain hold guarantees the last write of a stage lands before the next stage reads.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            RUN: begin
                if (k_q == K_LAST) begin
                    if (LAT > 0) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else if (s_q == S_LAST) begin
                        state_d = DONE;
                    end else begin
                        s_d = s_q + 1'b1;
                        k_d = '0;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    if (s_q == S_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        s_d     = s_q + 1'b1;
                        k_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                s_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit s of addrA is always clear, so OR-ing in h is the same as adding it.
    always_comb begin
        kExt        = {1'b0, k_q};
        hVal        = {{(LOG2_PTS-1){1'b0}}, 1'b1} << s_q;
        pos         = kExt & (hVal - 1'b1);
        grp         = kExt >> s_q;
        addrA       = ((grp << s_q) << 1) | pos;
        twFull      = pos << (S_LAST - s_q);
        rd_en_o     = (state_q == RUN);
        rd_addr_a_o = rd_en_o ? addrA : '0;
        rd_addr_b_o = rd_en_o ? (addrA | hVal) : '0;
        tw_idx_o    = rd_en_o ? twFull[KW-1:0] : '0;
        busy_o      = (state_q == RUN) || (state_q == DRAIN);
        done_o      = (state_q == DONE);
        stage_o     = s_q;
    end

    generate
        if (LAT == 0) begin : gNoPipe
            assign wr_en_o     = rd_en_o;
            assign wr_addr_a_o = rd_addr_a_o;
            assign wr_addr_b_o = rd_addr_b_o;
        end else begin : gPipe
            logic                pipeEn_q [LAT];
            logic [LOG2_PTS-1:0] pipeA_q  [LAT];
            logic [LOG2_PTS-1:0] pipeB_q  [LAT];

            // Read addresses are already zero when idle, so the delayed copies need no masking.
            always_ff @(posedge clk_i or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < LAT; i++) begin
                        pipeEn_q[i] <= 1'b0;
                        pipeA_q[i]  <= '0;
                        pipeB_q[i]  <= '0;
                    end
                end else begin
                    pipeEn_q[0] <= rd_en_o;
                    pipeA_q[0]  <= rd_addr_a_o;
                    pipeB_q[0]  <= rd_addr_b_o;
                    for (int i = 1; i < LAT; i++) begin
                        pipeEn_q[i] <= pipeEn_q[i-1];
                        pipeA_q[i]  <= pipeA_q[i-1];
                        pipeB_q[i]  <= pipeB_q[i-1];
                    end
                end
            end

            assign wr_en_o     = pipeEn_q[LAT-1];
            assign wr_addr_a_o = pipeA_q[LAT-1];
            assign wr_addr_b_o = pipeB_q[LAT-1];
        end
    endgenerate

endmodule

// File: doc/fft_sched.md
# fft_sched

Sequencing controller for an in-place radix-2 decimation-in-time FFT built around a single butterfly (MAC) unit. It walks all stages and butterflies and drives, each cycle, the sample-RAM read addresses, the twiddle-ROM index and delayed write-back addresses. The butterfly computes `C = A + B·W` and `D = A − B·W`. The block sits between the top-level FFT control (`start`/`done`) and the sample RAM, twiddle ROM and butterfly. Input samples are already in bit-reversed order in the RAM; loading and unloading are outside this block.

## Interface
- `LOG2_PTS`, default 3: log2 of FFT points P; legal range ≥ 2.
- `LAT`, default 1: cycles from read issue to the write of that butterfly's results; legal range 0..7.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `start` input 1: launch request; sampled only in IDLE.
- `busy` output 1: high in RUN and DRAIN.
- `done` output 1: one-cycle completion pulse.
- `stage` output max(1,clog2(LOG2_PTS)): current stage s, for optional scaling logic.
- `rd_en` output 1: read/butterfly issue valid this cycle.
- `rd_addr_a` output LOG2_PTS: RAM address feeding butterfly input A.
- `rd_addr_b` output LOG2_PTS: RAM address feeding butterfly input B.
- `tw_idx` output LOG2_PTS-1: twiddle ROM index t, where W = e^(−j2πt/P).
- `wr_en` output 1: write-back valid.
- `wr_addr_a` output LOG2_PTS: destination of butterfly output C.
- `wr_addr_b` output LOG2_PTS: destination of butterfly output D.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN when `start`=1. Clear s=0 and k=0.
- RUN: issue one butterfly per cycle with `rd_en`=1, for k = 0..P/2−1.
  - h = 2^s; pos = k & (h−1); grp = k >> s.
  - `rd_addr_a` = (grp << (s+1)) | pos.
  - `rd_addr_b` = `rd_addr_a` + h.
  - `tw_idx` = pos << (LOG2_PTS−1−s).
- RUN exit, taken on the cycle issuing k = P/2−1:
  - LAT>0: go to DRAIN.
  - LAT=0 and s < last: s+1, k=0, stay in RUN.
  - LAT=0 and s = last: go to DONE.
- DRAIN: hold for exactly LAT cycles with `rd_en`=0. This guarantees every write of stage s lands before stage s+1's first read. Then go to RUN with s+1 and k=0, or to DONE if s = LOG2_PTS−1.
- DONE: `done`=1 for one cycle, then IDLE.
- Write pipeline: a LAT-deep shift register carries {`rd_en`, `rd_addr_a`, `rd_addr_b`} to {`wr_en`, `wr_addr_a`, `wr_addr_b`}. LAT=0 makes the path combinational (write in the same cycle as the read).
- `start` in RUN, DRAIN or DONE is ignored. Back-to-back runs are allowed: `start` high in the cycle after DONE launches again.
- When `rd_en`/`wr_en` = 0, address and index outputs are 0.

## Timing
- Reset values, asynchronous: state IDLE, s=0, k=0, write pipeline cleared. All outputs are 0.
- Reset mid-run aborts immediately. No `wr_en` is asserted after `reset` deasserts until a new `start`.
- Cycle numbering: `start` is sampled at edge 0; cycle 1 is the first RUN cycle.
- Per stage: P/2 issue cycles plus LAT drain cycles. `done` is high in cycle 1 + LOG2_PTS·(P/2+LAT). For P=8, LAT=1 that is cycle 16.
- Write timing: `wr_en` for issue cycle t is high in cycle t+LAT. The RAM commits at the rising edge ending that cycle.
- The butterfly registers its outputs on the falling clock edge. With LAT=0, the outputs are valid at the rising edge ending the issue cycle. External pipeline registers add to LAT.
- `busy` rises in cycle 1 and falls in the DONE cycle.

## Test plan
- Reset values: assert `reset` with no clock running → all outputs 0 and state IDLE; pulse `start` → `busy` rises the next cycle.
- Full P=8, LAT=1 address sequence:
  - Stage 0 pairs (a,b):t = (0,1):0, (2,3):0, (4,5):0, (6,7):0.
  - Stage 1: (0,2):0, (1,3):2, (4,6):0, (5,7):2.
  - Stage 2: (0,4):0, (1,5):1, (2,6):2, (3,7):3.
  - Expected timing: `rd_en` high in cycles 1–4, 6–9, 11–14; `wr_en` high in cycles 2–5, 7–10, 12–15; `done` pulse in cycle 16.
- LAT=0 with P=8: no DRAIN state; `rd_en` = `wr_en` continuously high in cycles 1–12; `done` in cycle 13.
- `start` held high throughout a run: there is exactly one launch per pass, and a relaunch occurs in the cycle after DONE.
- Reset asserted in cycle 7 of a P=8, LAT=1 run: all outputs 0 immediately; no `wr_en` after release; a new `start` reproduces the full sequence from the stage 0, k=0 entries.
- P=16, LAT=3 end-to-end: write a golden 16-point vector into a RAM model with this block driving a butterfly model. The output must match a reference FFT within Q-format rounding, and `done` must fire in cycle 45.
